// File: rtl/ball_motion_ctrl_pkg.sv
// Shared constants and types for the ball motion sequencer.
// Holds direction codes, screen size, default ball size and FSM states.
package ball_motion_ctrl_pkg;

  localparam int POS_W = 11;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int BALL_W_DEF = 8;

  localparam logic [1:0] DIR_POS = 2'b01;
  localparam logic [1:0] DIR_NEG = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_STEP,
    S_DONE
  } state_t;

  function automatic logic dir_valid(
    input logic [1:0] d
  );
    return (d == DIR_POS) || (d == DIR_NEG);
  endfunction

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Frame command/status bundle of the ball motion sequencer.
// master: frame source + collision logic; slave: the sequencer.
interface ball_motion_ctrl_if;
  import ball_motion_ctrl_pkg::*;

  logic             frame_tick;
  logic [1:0]       dir_x;
  logic [1:0]       dir_y;
  logic [2:0]       speed;
  logic             stop_right;
  logic             stop_left;
  logic             stop_up;
  logic             stop_down;
  logic [POS_W-1:0] x_ball;
  logic [POS_W-1:0] y_ball;
  logic [4:0]       ball_width;
  logic             busy;
  logic [3:0]       blocked;
  logic             frame_done;

  modport master (
    output frame_tick, dir_x, dir_y, speed,
    output stop_right, stop_left,
    output stop_up, stop_down,
    input  x_ball, y_ball, ball_width,
    input  busy, blocked, frame_done
  );

  modport slave (
    input  frame_tick, dir_x, dir_y, speed,
    input  stop_right, stop_left,
    input  stop_up, stop_down,
    output x_ball, y_ball, ball_width,
    output busy, blocked, frame_done
  );

endinterface

// File: rtl/ball_axis_step.sv
// One axis of ball motion: position, remaining steps, limit/stop check.
// load latches dir/speed; en performs one pixel step or refuses it.
module ball_axis_step
  import ball_motion_ctrl_pkg::*;
#(
  parameter int INIT = 20,
  parameter int MIN  = 0,
  parameter int MAX  = 632
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [1:0]       dir,
  input  logic [2:0]       speed,
  input  logic             en,
  input  logic             stop_pos,
  input  logic             stop_neg,
  output logic [POS_W-1:0] pos,
  output logic             active,
  output logic             blk_pos,
  output logic             blk_neg
);

  localparam logic [POS_W-1:0] INIT_P = POS_W'(INIT);
  localparam logic [POS_W-1:0] MIN_P  = POS_W'(MIN);
  localparam logic [POS_W-1:0] MAX_P  = POS_W'(MAX);

  logic [2:0] rem;
  logic [1:0] dir_q;
  logic       hit;

  assign active = (rem != 3'd0);

  // A step is refused on a wall flag or at the screen limit.
  always_comb begin
    hit = 1'b0;
    unique case (1'b1)
      (dir_q == DIR_POS): hit = stop_pos || (pos >= MAX_P);
      (dir_q == DIR_NEG): hit = stop_neg || (pos <= MIN_P);
      default:            hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos     <= INIT_P;
      rem     <= 3'd0;
      dir_q   <= 2'b00;
      blk_pos <= 1'b0;
      blk_neg <= 1'b0;
    end else if (load) begin
      dir_q   <= dir;
      rem     <= dir_valid(dir) ? speed : 3'd0;
      blk_pos <= 1'b0;
      blk_neg <= 1'b0;
    end else if (en && active) begin
      if (hit) begin
        rem <= 3'd0;
        if (dir_q == DIR_POS) blk_pos <= 1'b1;
        else                  blk_neg <= 1'b1;
      end else begin
        rem <= rem - 3'd1;
        if (dir_q == DIR_POS) pos <= pos + 1'b1;
        else                  pos <= pos - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion sequencer: steps x then y one pixel per 2 cycles.
// Ports: clk, rst_n (async, active-low), bus (slave command/status).
module ball_motion_ctrl
  import ball_motion_ctrl_pkg::*;
#(
  parameter int X_INIT = 20,
  parameter int Y_INIT = 20,
  parameter int BALL_W = BALL_W_DEF,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = SCR_W - BALL_W,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = SCR_H - BALL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  ball_motion_ctrl_if.slave bus
);

  state_t state, state_nx;
  logic   load, en_x, en_y;
  logic   act_x, act_y;
  logic   bx_pos, bx_neg;
  logic   by_pos, by_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // x axis owns STEP until its counter drains, then y.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    en_x     = 1'b0;
    en_y     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.frame_tick) begin
          load     = 1'b1;
          state_nx = S_SETTLE;
        end
      end
      S_SETTLE: state_nx = S_STEP;
      S_STEP: begin
        en_x     = act_x;
        en_y     = !act_x && act_y;
        state_nx = (act_x || act_y) ? S_SETTLE : S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  ball_axis_step #(
    .INIT(X_INIT), .MIN(X_MIN), .MAX(X_MAX)
  ) u_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .dir      (bus.dir_x),
    .speed    (bus.speed),
    .en       (en_x),
    .stop_pos (bus.stop_right),
    .stop_neg (bus.stop_left),
    .pos      (bus.x_ball),
    .active   (act_x),
    .blk_pos  (bx_pos),
    .blk_neg  (bx_neg)
  );

  ball_axis_step #(
    .INIT(Y_INIT), .MIN(Y_MIN), .MAX(Y_MAX)
  ) u_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .dir      (bus.dir_y),
    .speed    (bus.speed),
    .en       (en_y),
    .stop_pos (bus.stop_down),
    .stop_neg (bus.stop_up),
    .pos      (bus.y_ball),
    .active   (act_y),
    .blk_pos  (by_pos),
    .blk_neg  (by_neg)
  );

  // {right, left, up, down}; y positive is down.
  assign bus.blocked    = {bx_pos, bx_neg, by_neg, by_pos};
  assign bus.ball_width = 5'(BALL_W);
  assign bus.busy       = (state != S_IDLE);
  assign bus.frame_done = (state == S_DONE);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: moves, walls, limits, resets.
// Main DUT starts at (20,20); a second instance starts at x=630.
module tb_ball_motion_ctrl;
  import ball_motion_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wall_en = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   t;
  int   lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ball_motion_ctrl_if bif();
  ball_motion_ctrl_if bif2();

  ball_motion_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  ball_motion_ctrl #(.X_INIT(630)) u_lim (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif2)
  );

  // Wall model: a block sits just right of x = 22.
  always_comb
    bif.stop_right = wall_en && (bif.x_ball == 11'd22);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic fire(output int tt);
    @(negedge clk);
    bif.frame_tick = 1'b1;
    tt = cyc;
    @(negedge clk);
    bif.frame_tick = 1'b0;
  endtask

  task automatic wait_done(
    input int    tt,
    input string tag,
    input int    exp
  );
    int l;
    while (!bif.frame_done && cyc < tt + 40)
      @(negedge clk);
    l = bif.frame_done ? cyc - tt : -1;
    chk(tag, l, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bif.frame_tick  = 1'b0;
    bif.dir_x       = 2'b00;
    bif.dir_y       = 2'b00;
    bif.speed       = 3'd0;
    bif.stop_left   = 1'b0;
    bif.stop_up     = 1'b0;
    bif.stop_down   = 1'b0;
    bif2.frame_tick = 1'b0;
    bif2.dir_x      = 2'b00;
    bif2.dir_y      = 2'b00;
    bif2.speed      = 3'd0;
    bif2.stop_right = 1'b0;
    bif2.stop_left  = 1'b0;
    bif2.stop_up    = 1'b0;
    bif2.stop_down  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_x", bif.x_ball, 20);
    chk("rst_y", bif.y_ball, 20);
    chk("rst_busy", bif.busy, 0);
    chk("rst_blk", bif.blocked, 0);
    chk("rst_done", bif.frame_done, 0);
    chk("rst_width", bif.ball_width, 8);
    chk("rst_x2", bif2.x_ball, 630);
    rst_n = 1'b1;

    // free move right by 3
    bif.dir_x = 2'b01;
    bif.dir_y = 2'b00;
    bif.speed = 3'd3;
    fire(t);
    chk("free_busy", bif.busy, 1);
    wait_cyc(t + 3);
    chk("free_x1", bif.x_ball, 21);
    wait_cyc(t + 5);
    chk("free_x2", bif.x_ball, 22);
    wait_cyc(t + 7);
    chk("free_x3", bif.x_ball, 23);
    wait_done(t, "free_lat", 9);
    chk("free_y", bif.y_ball, 20);
    chk("free_blk", bif.blocked, 0);
    @(negedge clk);
    chk("free_idle", bif.busy, 0);

    // wall at x = 22
    do_reset();
    chk("wall_x0", bif.x_ball, 20);
    wall_en = 1'b1;
    bif.speed = 3'd5;
    fire(t);
    wait_done(t, "wall_lat", 9);
    chk("wall_x", bif.x_ball, 22);
    chk("wall_blk", bif.blocked, 4'b1000);
    wall_en = 1'b0;

    // diagonal up-left by 2, x first
    do_reset();
    bif.dir_x = 2'b10;
    bif.dir_y = 2'b10;
    bif.speed = 3'd2;
    fire(t);
    wait_cyc(t + 3);
    chk("diag_x1", bif.x_ball, 19);
    chk("diag_y1", bif.y_ball, 20);
    wait_cyc(t + 5);
    chk("diag_x2", bif.x_ball, 18);
    chk("diag_y2", bif.y_ball, 20);
    wait_cyc(t + 7);
    chk("diag_y3", bif.y_ball, 19);
    wait_done(t, "diag_lat", 11);
    chk("diag_x", bif.x_ball, 18);
    chk("diag_y", bif.y_ball, 18);
    chk("diag_blk", bif.blocked, 0);

    // speed 0
    bif.dir_x = 2'b01;
    bif.dir_y = 2'b00;
    bif.speed = 3'd0;
    fire(t);
    wait_done(t, "spd0_lat", 3);
    chk("spd0_x", bif.x_ball, 18);

    // no direction code
    bif.dir_x = 2'b11;
    bif.speed = 3'd7;
    fire(t);
    wait_done(t, "nodir_lat", 3);
    chk("nodir_x", bif.x_ball, 18);
    chk("nodir_y", bif.y_ball, 18);

    // left flag refuses the first step
    bif.dir_x = 2'b10;
    bif.speed = 3'd3;
    bif.stop_left = 1'b1;
    fire(t);
    wait_done(t, "left_lat", 5);
    chk("left_x", bif.x_ball, 18);
    chk("left_blk", bif.blocked, 4'b0100);
    bif.stop_left = 1'b0;

    // screen limit on second instance
    @(negedge clk);
    bif2.dir_x = 2'b01;
    bif2.speed = 3'd5;
    bif2.frame_tick = 1'b1;
    t = cyc;
    @(negedge clk);
    bif2.frame_tick = 1'b0;
    while (!bif2.frame_done && cyc < t + 40)
      @(negedge clk);
    lat = bif2.frame_done ? cyc - t : -1;
    chk("lim_lat", lat, 9);
    chk("lim_x", bif2.x_ball, 632);
    chk("lim_blk", bif2.blocked, 4'b1000);

    // second tick mid-frame is dropped
    bif.dir_x = 2'b01;
    bif.speed = 3'd3;
    fire(t);
    wait_cyc(t + 4);
    bif.frame_tick = 1'b1;
    @(negedge clk);
    bif.frame_tick = 1'b0;
    wait_done(t, "dup_lat", 9);
    chk("dup_x", bif.x_ball, 21);
    repeat (3) @(negedge clk);
    chk("dup_idle", bif.busy, 0);
    chk("dup_x_hold", bif.x_ball, 21);

    // reset mid-frame aborts
    fire(t);
    wait_cyc(t + 5);
    chk("abort_pre_x", bif.x_ball, 23);
    rst_n = 1'b0;
    #1;
    chk("abort_x", bif.x_ball, 20);
    chk("abort_y", bif.y_ball, 20);
    chk("abort_busy", bif.busy, 0);
    chk("abort_done", bif.frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // following tick runs normally
    bif.speed = 3'd1;
    fire(t);
    wait_done(t, "post_lat", 5);
    chk("post_x", bif.x_ball, 21);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
